gf180mcu_fd_sc_mcu7t5v0__and4_dfilt_1: RTL and testbench

Registered, glitch-filtered 4-input AND qualifier. It sits directly downstream of the and4 cell's function, on paths where the and4 output Z gates a state change. The block ANDs A1..A4 internally and asserts Q only after the product has been sampled high for DEPTH consecutive enabled clock edges. Q deasserts under the same rule when the fall filter is compiled in. QP gives a one-cycle pulse on every Q rise, for edge-triggered consumers.

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__and4_dfilt_1.sv | 115 +++++++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__and4_dfilt_1.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__and4_dfilt_1.sv
// Registered, run-length glitch filter on a 4-input AND; Q changes after DEPTH agreeing enabled samples.
// Optional symmetric fall filter: define GF180MCU_FD_SC_MCU7T5V0__AND4_DFILT_FALL_EN.
module gf180mcu_fd_sc_mcu7t5v0__and4_dfilt_1 #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned CW    = 4
) (
    input  logic CLK,
    input  logic R,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic A4,
    input  logic E,
    output logic Q,
    output logic QP
);

    typedef enum logic [1:0] {
        LOW  = 2'd0,
        RISE = 2'd1,
        HIGH = 2'd2,
        FALL = 2'd3
    } state_t;

    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    state_t        st;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          z;

    assign z       = A1 & A2 & A3 & A4;
    assign cnt_inc = cnt + CW'(1);

    // State, run counter and both outputs update together on each enabled edge.
    always_ff @(posedge CLK or posedge R) begin
        if (R) begin
            st  <= LOW;
            cnt <= '0;
            Q   <= 1'b0;
            QP  <= 1'b0;
        end else if (!E) begin
            QP <= 1'b0;
        end else begin
            QP <= 1'b0;
            case (st)
                LOW: begin
                    if (z) begin
                        if (DEPTH == 1) begin
                            st  <= HIGH;
                            cnt <= '0;
                            Q   <= 1'b1;
                            QP  <= 1'b1;
                        end else begin
                            st  <= RISE;
                            cnt <= CW'(1);
                        end
                    end else begin
                        cnt <= '0;
                        Q   <= 1'b0;
                    end
                end
                RISE: begin
                    if (!z) begin
                        st  <= LOW;
                        cnt <= '0;
                    end else if (cnt_inc == DEPTH_W) begin
                        st  <= HIGH;
                        cnt <= '0;
                        Q   <= 1'b1;
                        QP  <= 1'b1;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HIGH: begin
                    if (z) begin
                        cnt <= '0;
                        Q   <= 1'b1;
`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DFILT_FALL_EN
                    end else if (DEPTH != 1) begin
                        st  <= FALL;
                        cnt <= CW'(1);
`endif
                    end else begin
                        st  <= LOW;
                        cnt <= '0;
                        Q   <= 1'b0;
                    end
                end
`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DFILT_FALL_EN
                FALL: begin
                    if (z) begin
                        st  <= HIGH;
                        cnt <= '0;
                    end else if (cnt_inc == DEPTH_W) begin
                        st  <= LOW;
                        cnt <= '0;
                        Q   <= 1'b0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
`endif
                // Illegal (or, without the fall filter, unreachable FALL) encodings recover to LOW.
                default: begin
                    st  <= LOW;
                    cnt <= '0;
                    Q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__and4_dfilt_1.sv
// Bench for the and4 glitch filter: DEPTH 3, 1 and 15 instances driven in parallel, checked
// against a run-length model (Q flips once DEPTH consecutive enabled samples disagree with it).
module tb_gf180mcu_fd_sc_mcu7t5v0__and4_dfilt_1;

`ifdef GF180MCU_FD_SC_MCU7T5V0__AND4_DFILT_FALL_EN
    localparam bit FALL_EN = 1'b1;
`else
    localparam bit FALL_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic R;
    logic [3:0] a;
    logic E;
    logic q_out  [3];
    logic qp_out [3];

    int checks = 0;
    int errors = 0;

    int  dep [3];
    bit  mq  [3];
    bit  mqp [3];
    int  run [3];

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu7t5v0__and4_dfilt_1 #(.DEPTH(3), .CW(4)) u_d3 (
        .CLK(CLK), .R(R), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
        .E(E), .Q(q_out[0]), .QP(qp_out[0]));
    gf180mcu_fd_sc_mcu7t5v0__and4_dfilt_1 #(.DEPTH(1), .CW(4)) u_d1 (
        .CLK(CLK), .R(R), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
        .E(E), .Q(q_out[1]), .QP(qp_out[1]));
    gf180mcu_fd_sc_mcu7t5v0__and4_dfilt_1 #(.DEPTH(15), .CW(4)) u_d15 (
        .CLK(CLK), .R(R), .A1(a[0]), .A2(a[1]), .A3(a[2]), .A4(a[3]),
        .E(E), .Q(q_out[2]), .QP(qp_out[2]));

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mq[k]  = 1'b0;
            mqp[k] = 1'b0;
            run[k] = 0;
        end
    endtask

    // Reference: count enabled samples disagreeing with Q; flip Q after DEPTH of them.
    task automatic model_edge(input bit z, input bit en);
        for (int k = 0; k < 3; k++) begin
            mqp[k] = 1'b0;
            if (en) begin
                if (z != mq[k]) begin
                    run[k]++;
                    if (!mq[k] && run[k] >= dep[k]) begin
                        mq[k]  = 1'b1;
                        mqp[k] = 1'b1;
                        run[k] = 0;
                    end else if (mq[k] && (!FALL_EN || run[k] >= dep[k])) begin
                        mq[k]  = 1'b0;
                        run[k] = 0;
                    end
                end else begin
                    run[k] = 0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_q_d%0d", tag, dep[k]), q_out[k], mq[k]);
            chk($sformatf("%s_qp_d%0d", tag, dep[k]), qp_out[k], mqp[k]);
        end
    endtask

    // Called at a negedge; applies inputs, clocks once, checks, returns at the next negedge.
    task automatic step(input logic [3:0] av, input logic ev, input string tag);
        a = av;
        E = ev;
        @(posedge CLK);
        #1;
        model_edge(&av, ev);
        check_all(tag);
        @(negedge CLK);
    endtask

    // Async reset pulse: Q must drop immediately and the edge under reset is not counted.
    task automatic pulse_reset(input string tag);
        R = 1'b1;
        #1;
        model_reset();
        check_all({tag, "_async"});
        @(posedge CLK);
        #1;
        check_all({tag, "_held"});
        @(negedge CLK);
        R = 1'b0;
    endtask

    bit level;

    initial begin
        dep[0] = 3;
        dep[1] = 1;
        dep[2] = 15;
        R = 1'b1;
        a = 4'h0;
        E = 1'b0;
        model_reset();
        @(negedge CLK);
        pulse_reset("rst");

        // Steady 1111: D3 rises after edge 3, QP clears after edge 4.
        for (int i = 0; i < 4; i++) step(4'hF, 1'b1, "hold");

        // Glitch on A3 mid-RISE restarts the run.
        pulse_reset("rst2");
        step(4'hF, 1'b1, "gl");
        step(4'hF, 1'b1, "gl");
        step(4'hB, 1'b1, "gl");
        for (int i = 0; i < 3; i++) step(4'hF, 1'b1, "gl_run");

        // E toggling stretches but does not break the run.
        pulse_reset("rst3");
        for (int i = 0; i < 5; i++) step(4'hF, (i % 2 == 0) ? 1'b1 : 1'b0, "en_tog");

        // From Q=1: a single low sample, then back high.
        step(4'hF, 1'b1, "hi");
        step(4'h0, 1'b1, "fall_gl");
        for (int i = 0; i < 4; i++) step(4'hF, 1'b1, "fall_rec");

        // Sustained low, then an async reset mid-RISE.
        for (int i = 0; i < 3; i++) step(4'h7, 1'b1, "fall3");
        step(4'hF, 1'b1, "rise_pre");
        step(4'hF, 1'b1, "rise_pre");
        pulse_reset("mid_rise");
        for (int i = 0; i < 3; i++) step(4'hF, 1'b1, "post_rst");

        // Long run: D15 rises on exactly the 15th edge.
        pulse_reset("rst4");
        for (int i = 0; i < 17; i++) step(4'hF, 1'b1, "d15");

        // Randomized: sticky level with occasional glitches, enable gaps and resets.
        level = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] av;
            if ($urandom_range(0, 24) == 0) level = ~level;
            av = level ? 4'hF : 4'($urandom_range(0, 14));
            if ($urandom_range(0, 9) == 0) av = 4'($urandom);
            if ($urandom_range(0, 499) == 0) pulse_reset("rnd_rst");
            step(av, ($urandom_range(0, 5) != 0), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
